// File: rtl/jrb8_spi_pkg.sv
// rtl/jrb8_spi_pkg.sv - opcodes and FSM state type for the SPI memory responder
package jrb8_spi_pkg;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        IGNORE
    } spi_resp_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - synchronizes sclk/cs_n/mosi into clk and emits one-clk edge pulses
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;
    logic                   cs_n_prev_q;

    // cs_n resets high so releasing reset with the bus idle produces no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            cs_n_q      <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_n_q      <= {cs_n_q[SYNC_STAGES-2:0], cs_n};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            cs_n_prev_q <= cs_n_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_fall   = ~cs_n_q[SYNC_STAGES-1] & cs_n_prev_q;
    assign cs_rise   = cs_n_q[SYNC_STAGES-1] & ~cs_n_prev_q;
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 target bridging READ/WRITE + 16-bit address to a memory port
// Multi-byte bursts with address auto-increment are enabled by defining SPI_RESP_BURST_EN.
module spi_mem_responder
    import jrb8_spi_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              err_cmd
);

`ifdef SPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi_s    (mosi_s)
    );

    spi_resp_state_e   state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_read_q, is_read_d;
    logic              skip_q, skip_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [7:0]        rx_byte;
    logic              rx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_hi_q <= 8'h00;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            skip_q    <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            wdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            skip_q    <= skip_d;
            miso_q    <= miso_d;
            miso_oe_q <= miso_oe_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        skip_d    = skip_q;
        miso_d    = miso_q;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rx_byte   = {shift_q[6:0], mosi_s};
        rx_done   = sclk_rise && (bit_cnt_q == 3'd7);

        // Burst writes: the address moves on only after the strobe has used it
        if (BURST && mem_we_q && (state_q == WR_DATA)) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            CMD, ADDR_HI, ADDR_LO, WR_DATA: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                if (rx_done) begin
                    case (state_q)
                        CMD: begin
                            if (rx_byte == OPC_READ) begin
                                is_read_d = 1'b1;
                                state_d   = ADDR_HI;
                            end else if (rx_byte == OPC_WRITE) begin
                                is_read_d = 1'b0;
                                state_d   = ADDR_HI;
                            end else begin
                                err_d   = 1'b1;
                                state_d = IGNORE;
                            end
                        end
                        ADDR_HI: begin
                            addr_hi_d = rx_byte;
                            state_d   = ADDR_LO;
                        end
                        ADDR_LO: begin
                            addr_d = ADDR_W'({addr_hi_q, rx_byte});
                            if (is_read_q) begin
                                mem_re_d = 1'b1;
                                skip_d   = 1'b1;
                                state_d  = RD_FETCH;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                        default: begin
                            mem_we_d = 1'b1;
                            wdata_d  = rx_byte;
                            state_d  = BURST ? WR_DATA : IGNORE;
                        end
                    endcase
                end
            end
            RD_FETCH: begin
                if (sclk_fall) begin
                    skip_d = 1'b0;
                end
                // mem_re_q low means the memory has had its cycle and mem_rdata is valid
                if (!mem_re_q) begin
                    shift_d   = mem_rdata;
                    miso_d    = mem_rdata[7];
                    bit_cnt_d = 3'd0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                // The fall closing the last address bit carries no data and is skipped
                if (sclk_fall) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (BURST) begin
                            addr_d   = addr_q + ADDR_W'(1);
                            mem_re_d = 1'b1;
                            state_d  = RD_FETCH;
                        end else begin
                            miso_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        miso_d    = shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            IGNORE: begin
                miso_d = 1'b0;
            end
        endcase

        // A completing write byte still strobes; a pending read is dropped
        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            skip_d    = 1'b0;
            miso_d    = 1'b0;
            mem_re_d  = 1'b0;
        end

        miso_oe_d = (state_d == RD_DATA) ||
                    ((state_d == RD_FETCH) && ((state_q == RD_DATA) || miso_oe_q));
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign mem_addr  = addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign err_cmd   = err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb/tb_spi_mem_responder.sv - randomized self-checking bench for spi_mem_responder
module tb_spi_mem_responder;

    localparam int HALF = 80;
`ifdef SPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, mem_re, mem_we, busy, err_cmd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;

    logic [7:0]  env_mem [65536];
    logic [7:0]  ref_mem [65536];
    logic [15:0] re_addr_q[$];
    logic [15:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          oe_seen  = 0;

    always #5 clk = ~clk;

    spi_mem_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .err_cmd   (err_cmd)
    );

    // Synchronous memory seen by the DUT, plus strobe logging
    always @(negedge clk) begin
        if (mem_re) begin
            re_addr_q.push_back(mem_addr);
            mem_rdata = env_mem[mem_addr];
        end
        if (mem_we) begin
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            env_mem[mem_addr] = mem_wdata;
        end
        if (miso_oe) oe_seen++;
    end

    task automatic clear_log();
        re_addr_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
        oe_seen = 0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            rx[i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_read(input logic [15:0] a, input int nb);
        logic [7:0] r;
        rx_q.delete();
        cs_n = 1'b0;
        #HALF;
        spi_byte(8'h03, r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        for (int k = 0; k < nb; k++) begin
            spi_byte(8'h00, r);
            rx_q.push_back(r);
        end
    endtask

    task automatic spi_write(input logic [15:0] a);
        logic [7:0] r;
        cs_n = 1'b0;
        #HALF;
        spi_byte(8'h02, r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        foreach (tx_q[k]) spi_byte(tx_q[k], r);
    endtask

    task automatic spi_end();
        #HALF;
        cs_n = 1'b1;
        mosi = 1'b0;
        #(2*HALF);
    endtask

    task automatic test_reset();
        #10;
        n_checks++;
        if ({miso, miso_oe, mem_re, mem_we, busy, err_cmd} !== 6'b0) begin
            n_fails++;
            $display("FAIL reset_ctrl: got %b expected 000000", {miso, miso_oe, mem_re, mem_we, busy, err_cmd});
        end
        n_checks++;
        if (mem_addr !== 16'h0000) begin
            n_fails++;
            $display("FAIL reset_addr: got %h expected 0000", mem_addr);
        end
        n_checks++;
        if (mem_wdata !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_wdata: got %h expected 00", mem_wdata);
        end
        #10;
        rst = 1'b0;
        #40;
    endtask

    task automatic test_read();
        logic [15:0] a, ea, ga;
        int nb;
        nb = BURST ? 3 : 1;
        for (int t = 0; t < 5; t++) begin
            a = (t == 0) ? 16'h1234 : 16'($urandom);
            if (t == 0) begin
                env_mem[a] = 8'hA5;
                ref_mem[a] = 8'hA5;
            end
            clear_log();
            spi_read(a, nb);
            for (int k = 0; k < nb; k++) begin
                ea = a + 16'(k);
                n_checks++;
                if (rx_q[k] !== ref_mem[ea]) begin
                    n_fails++;
                    $display("FAIL read_data @%h: got %h expected %h", ea, rx_q[k], ref_mem[ea]);
                end
            end
            #HALF;
            n_checks++;
            if (miso_oe !== BURST) begin
                n_fails++;
                $display("FAIL read_oe_after_byte: got %b expected %b", miso_oe, BURST);
            end
            cs_n = 1'b1;
            #(2*HALF);
            n_checks++;
            if (re_addr_q.size() != (BURST ? nb + 1 : 1)) begin
                n_fails++;
                $display("FAIL read_re_count: got %0d expected %0d", re_addr_q.size(), BURST ? nb + 1 : 1);
            end
            ga = (re_addr_q.size() > 0) ? re_addr_q[0] : 16'hxxxx;
            n_checks++;
            if (ga !== a) begin
                n_fails++;
                $display("FAIL read_re_addr: got %h expected %h", ga, a);
            end
            n_checks++;
            if (we_addr_q.size() != 0 || busy !== 1'b0 || miso_oe !== 1'b0 || oe_seen == 0) begin
                n_fails++;
                $display("FAIL read_side: we=%0d busy=%b oe=%b oe_seen=%0d expected 0 0 0 >0",
                         we_addr_q.size(), busy, miso_oe, oe_seen);
            end
        end
    endtask

    task automatic test_write();
        logic [15:0] a, ea, ga;
        logic [7:0]  gd;
        int nexp;
        for (int t = 0; t < 5; t++) begin
            tx_q.delete();
            if (t == 0) begin
                a = 16'h007F;
                tx_q.push_back(8'h3C);
            end else if (t == 1) begin
                a = 16'hFFFF;
                tx_q.push_back(8'h11);
                tx_q.push_back(8'h22);
            end else begin
                a = 16'($urandom);
                tx_q.push_back(8'($urandom));
                tx_q.push_back(8'($urandom));
            end
            clear_log();
            spi_write(a);
            spi_end();
            nexp = BURST ? tx_q.size() : 1;
            n_checks++;
            if (we_addr_q.size() != nexp) begin
                n_fails++;
                $display("FAIL write_count @%h: got %0d expected %0d", a, we_addr_q.size(), nexp);
            end
            for (int k = 0; k < nexp; k++) begin
                ea = a + 16'(k);
                ga = (k < we_addr_q.size()) ? we_addr_q[k] : 16'hxxxx;
                gd = (k < we_data_q.size()) ? we_data_q[k] : 8'hxx;
                n_checks++;
                if (ga !== ea || gd !== tx_q[k]) begin
                    n_fails++;
                    $display("FAIL write_beat %0d: got %h@%h expected %h@%h", k, gd, ga, tx_q[k], ea);
                end
                ref_mem[ea] = tx_q[k];
            end
            n_checks++;
            if (re_addr_q.size() != 0) begin
                n_fails++;
                $display("FAIL write_no_read: got %0d reads expected 0", re_addr_q.size());
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0]  op, r;
        logic [15:0] a;
        for (int t = 0; t < 2; t++) begin
            op = (t == 0) ? 8'h9F : 8'($urandom_range(4, 255));
            clear_log();
            cs_n = 1'b0;
            #HALF;
            spi_byte(op, r);
            for (int k = 0; k < 3; k++) spi_byte(8'($urandom), r);
            #HALF;
            n_checks++;
            if (err_cmd !== 1'b1) begin
                n_fails++;
                $display("FAIL bad_cmd_err op=%h: got %b expected 1", op, err_cmd);
            end
            n_checks++;
            if (re_addr_q.size() != 0 || we_addr_q.size() != 0 || oe_seen != 0) begin
                n_fails++;
                $display("FAIL bad_cmd_quiet op=%h: re=%0d we=%0d oe=%0d expected 0 0 0",
                         op, re_addr_q.size(), we_addr_q.size(), oe_seen);
            end
            cs_n = 1'b1;
            #(2*HALF);
        end
        a = 16'($urandom);
        spi_read(a, 1);
        spi_end();
        n_checks++;
        if (rx_q[0] !== ref_mem[a] || err_cmd !== 1'b1) begin
            n_fails++;
            $display("FAIL bad_cmd_recover: got %h err=%b expected %h err=1", rx_q[0], err_cmd, ref_mem[a]);
        end
    endtask

    task automatic test_abort_write();
        logic [15:0] a, ga;
        logic [7:0]  r, d2, gd;
        a  = 16'($urandom);
        d2 = 8'($urandom);
        clear_log();
        cs_n = 1'b0;
        #HALF;
        spi_byte(8'h02, r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        spi_bits(8'($urandom), 5);
        spi_end();
        n_checks++;
        if (we_addr_q.size() != 0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_write: we=%0d busy=%b oe=%b expected 0 0 0", we_addr_q.size(), busy, miso_oe);
        end
        tx_q.delete();
        tx_q.push_back(d2);
        clear_log();
        spi_write(a);
        spi_end();
        ga = (we_addr_q.size() > 0) ? we_addr_q[0] : 16'hxxxx;
        gd = (we_data_q.size() > 0) ? we_data_q[0] : 8'hxx;
        n_checks++;
        if (we_addr_q.size() != 1 || ga !== a || gd !== d2) begin
            n_fails++;
            $display("FAIL abort_then_write: got %0d writes %h@%h expected 1 %h@%h", we_addr_q.size(), gd, ga, d2, a);
        end
        ref_mem[a] = d2;
    endtask

    task automatic test_rst_mid();
        logic [7:0] r;
        cs_n = 1'b0;
        #HALF;
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_bits(8'h01, 4);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({miso, miso_oe, mem_re, mem_we, busy, err_cmd} !== 6'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
            n_fails++;
            $display("FAIL rst_mid: ctrl=%b addr=%h wdata=%h expected 000000 0000 00",
                     {miso, miso_oe, mem_re, mem_we, busy, err_cmd}, mem_addr, mem_wdata);
        end
        #19;
        cs_n = 1'b1;
        mosi = 1'b0;
        #40;
        rst = 1'b0;
        #40;
        spi_read(16'h0001, 1);
        spi_end();
        n_checks++;
        if (rx_q[0] !== ref_mem[1]) begin
            n_fails++;
            $display("FAIL rst_mid_read: got %h expected %h", rx_q[0], ref_mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [7:0]  d;
        for (int t = 0; t < 4; t++) begin
            a = 16'($urandom);
            d = 8'($urandom);
            tx_q.delete();
            tx_q.push_back(d);
            spi_write(a);
            spi_end();
            ref_mem[a] = d;
            spi_read(a, 1);
            spi_end();
            n_checks++;
            if (rx_q[0] !== ref_mem[a]) begin
                n_fails++;
                $display("FAIL back_to_back @%h: got %h expected %h", a, rx_q[0], ref_mem[a]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        test_reset();
        test_read();
        test_write();
        test_bad_cmd();
        test_abort_write();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
